// File: rtl/rob_multiport.sv
// Multi-port reorder buffer with in-order commit, out-of-order writeback and redirect flush.
// Optional per-entry pc/instr storage is enabled by defining ROB_DEBUG_INFO_EN.
module rob_multiport #(
   parameter int DEPTH    = 64,
   parameter int ENQ_W    = 2,
   parameter int WB_PORTS = 3,
   parameter int CMT_W    = 2,
   parameter int LREG_W   = 5,
   parameter int PREG_W   = 6,
   localparam int IDX_W   = $clog2(DEPTH)
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [ENQ_W-1:0]           enq_valid,
   input  logic [ENQ_W*LREG_W-1:0]    enq_lrd,
   input  logic [ENQ_W*PREG_W-1:0]    enq_prd,
   input  logic [ENQ_W*PREG_W-1:0]    enq_old_prd,
   input  logic [ENQ_W-1:0]           enq_need_wb,
   input  logic [ENQ_W*48-1:0]        enq_pc,
   input  logic [ENQ_W*32-1:0]        enq_instr,
   output logic                       enq_ready,
   output logic                       enq_robflag,
   output logic [IDX_W-1:0]           enq_robidx,
   input  logic [WB_PORTS-1:0]        wb_valid,
   input  logic [WB_PORTS-1:0]        wb_robflag,
   input  logic [WB_PORTS*IDX_W-1:0]  wb_robidx,
   output logic [CMT_W-1:0]           commit_valid,
   output logic [CMT_W*LREG_W-1:0]    commit_lrd,
   output logic [CMT_W*PREG_W-1:0]    commit_prd,
   output logic [CMT_W*PREG_W-1:0]    commit_old_prd,
   output logic [CMT_W*48-1:0]        commit_pc,
   output logic [CMT_W*32-1:0]        commit_instr,
   input  logic                       redirect_valid,
   input  logic                       redirect_robflag,
   input  logic [IDX_W-1:0]           redirect_robidx,
   output logic                       empty,
   output logic                       full,
   output logic [IDX_W:0]             count
);

   typedef logic [IDX_W:0] ptr_t;

   ptr_t enq_ptr, deq_ptr, redir_ptr, redir_span, enq_num, cmt_num;
   ptr_t enq_slot [ENQ_W];
   logic [IDX_W-1:0] cmt_idx [CMT_W];
   logic [DEPTH-1:0] ent_valid, ent_done, ent_flag, flush_vec;
   logic [LREG_W-1:0] ent_lrd     [DEPTH];
   logic [PREG_W-1:0] ent_prd     [DEPTH];
   logic [PREG_W-1:0] ent_old_prd [DEPTH];
   logic redir_hit;

   function automatic logic [IDX_W-1:0] dist_from(input int i, input logic [IDX_W-1:0] base);
      return IDX_W'(i) - base;
   endfunction

   assign count       = enq_ptr - deq_ptr;
   assign empty       = (enq_ptr == deq_ptr);
   assign full        = (enq_ptr[IDX_W-1:0] == deq_ptr[IDX_W-1:0]) && (enq_ptr[IDX_W] != deq_ptr[IDX_W]);
   assign enq_ready   = ((DEPTH - int'(count)) >= ENQ_W) && !redirect_valid;
   assign enq_robflag = enq_ptr[IDX_W];
   assign enq_robidx  = enq_ptr[IDX_W-1:0];

   // Only the contiguous prefix of enq_valid is accepted.
   always_comb begin
      logic run;
      run     = 1'b1;
      enq_num = '0;
      for (int k = 0; k < ENQ_W; k++) begin
         enq_slot[k] = enq_ptr + ptr_t'(k);
         run = run & enq_valid[k];
         if (run) enq_num = enq_num + ptr_t'(1);
      end
   end

   // A redirect only acts when it names a live entry of the current generation.
   assign redir_ptr  = {redirect_robflag, redirect_robidx};
   assign redir_hit  = redirect_valid && ent_valid[redirect_robidx] &&
                       (ent_flag[redirect_robidx] == redirect_robflag);
   assign redir_span = enq_ptr - redir_ptr;

   always_comb begin
      flush_vec = '0;
      for (int i = 0; i < DEPTH; i++)
         flush_vec[i] = redir_hit && (dist_from(i, redirect_robidx) != '0) &&
                        (ptr_t'(dist_from(i, redirect_robidx)) < redir_span);
   end

   // Commit lanes form an in-order prefix; entries being flushed never retire.
   always_comb begin
      logic ok;
      ok             = 1'b1;
      cmt_num        = '0;
      commit_valid   = '0;
      commit_lrd     = '0;
      commit_prd     = '0;
      commit_old_prd = '0;
      for (int k = 0; k < CMT_W; k++) begin
         cmt_idx[k] = deq_ptr[IDX_W-1:0] + IDX_W'(k);
         ok = ok & ent_valid[cmt_idx[k]] & ent_done[cmt_idx[k]] & !flush_vec[cmt_idx[k]];
         commit_valid[k] = ok;
         if (ok) cmt_num = cmt_num + ptr_t'(1);
         commit_lrd[k*LREG_W +: LREG_W]     = ent_lrd[cmt_idx[k]];
         commit_prd[k*PREG_W +: PREG_W]     = ent_prd[cmt_idx[k]];
         commit_old_prd[k*PREG_W +: PREG_W] = ent_old_prd[cmt_idx[k]];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         enq_ptr   <= '0;
         deq_ptr   <= '0;
         ent_valid <= '0;
         ent_done  <= '0;
         ent_flag  <= '0;
      end else begin
         for (int p = 0; p < WB_PORTS; p++)
            if (wb_valid[p] && ent_valid[wb_robidx[p*IDX_W +: IDX_W]] &&
                (ent_flag[wb_robidx[p*IDX_W +: IDX_W]] == wb_robflag[p]))
               ent_done[wb_robidx[p*IDX_W +: IDX_W]] <= 1'b1;
         for (int k = 0; k < CMT_W; k++)
            if (commit_valid[k]) ent_valid[cmt_idx[k]] <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            if (flush_vec[i]) ent_valid[i] <= 1'b0;
         for (int k = 0; k < ENQ_W; k++)
            if (enq_ready && (ptr_t'(k) < enq_num)) begin
               ent_valid[enq_slot[k][IDX_W-1:0]] <= 1'b1;
               ent_done[enq_slot[k][IDX_W-1:0]]  <= !enq_need_wb[k];
               ent_flag[enq_slot[k][IDX_W-1:0]]  <= enq_slot[k][IDX_W];
            end
         deq_ptr <= deq_ptr + cmt_num;
         if (redir_hit)      enq_ptr <= redir_ptr + ptr_t'(1);
         else if (enq_ready) enq_ptr <= enq_ptr + enq_num;
      end
   end

   always_ff @(posedge clock) begin
      for (int k = 0; k < ENQ_W; k++)
         if (enq_ready && (ptr_t'(k) < enq_num)) begin
            ent_lrd[enq_slot[k][IDX_W-1:0]]     <= enq_lrd[k*LREG_W +: LREG_W];
            ent_prd[enq_slot[k][IDX_W-1:0]]     <= enq_prd[k*PREG_W +: PREG_W];
            ent_old_prd[enq_slot[k][IDX_W-1:0]] <= enq_old_prd[k*PREG_W +: PREG_W];
         end
   end

`ifdef ROB_DEBUG_INFO_EN
   logic [47:0] ent_pc    [DEPTH];
   logic [31:0] ent_instr [DEPTH];

   always_ff @(posedge clock) begin
      for (int k = 0; k < ENQ_W; k++)
         if (enq_ready && (ptr_t'(k) < enq_num)) begin
            ent_pc[enq_slot[k][IDX_W-1:0]]    <= enq_pc[k*48 +: 48];
            ent_instr[enq_slot[k][IDX_W-1:0]] <= enq_instr[k*32 +: 32];
         end
   end

   always_comb begin
      commit_pc    = '0;
      commit_instr = '0;
      for (int k = 0; k < CMT_W; k++) begin
         commit_pc[k*48 +: 48]    = ent_pc[cmt_idx[k]];
         commit_instr[k*32 +: 32] = ent_instr[cmt_idx[k]];
      end
   end
`else
   logic unused_dbg;
   assign unused_dbg   = ^{enq_pc, enq_instr};
   assign commit_pc    = '0;
   assign commit_instr = '0;
`endif

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: directed table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_rob_multiport;
   localparam int DEPTH = 64, ENQ_W = 2, WB_PORTS = 3, CMT_W = 2, LREG_W = 5, PREG_W = 6;
   localparam int IDX_W = $clog2(DEPTH);

   logic clock, reset_n;
   logic [ENQ_W-1:0] enq_valid, enq_need_wb;
   logic [ENQ_W*LREG_W-1:0] enq_lrd;
   logic [ENQ_W*PREG_W-1:0] enq_prd, enq_old_prd;
   logic [ENQ_W*48-1:0] enq_pc;
   logic [ENQ_W*32-1:0] enq_instr;
   logic enq_ready, enq_robflag;
   logic [IDX_W-1:0] enq_robidx;
   logic [WB_PORTS-1:0] wb_valid, wb_robflag;
   logic [WB_PORTS*IDX_W-1:0] wb_robidx;
   logic [CMT_W-1:0] commit_valid;
   logic [CMT_W*LREG_W-1:0] commit_lrd;
   logic [CMT_W*PREG_W-1:0] commit_prd, commit_old_prd;
   logic [CMT_W*48-1:0] commit_pc;
   logic [CMT_W*32-1:0] commit_instr;
   logic redirect_valid, redirect_robflag;
   logic [IDX_W-1:0] redirect_robidx;
   logic empty, full;
   logic [IDX_W:0] count;

   rob_multiport dut (
      .clock(clock), .reset_n(reset_n),
      .enq_valid(enq_valid), .enq_lrd(enq_lrd), .enq_prd(enq_prd), .enq_old_prd(enq_old_prd),
      .enq_need_wb(enq_need_wb), .enq_pc(enq_pc), .enq_instr(enq_instr),
      .enq_ready(enq_ready), .enq_robflag(enq_robflag), .enq_robidx(enq_robidx),
      .wb_valid(wb_valid), .wb_robflag(wb_robflag), .wb_robidx(wb_robidx),
      .commit_valid(commit_valid), .commit_lrd(commit_lrd), .commit_prd(commit_prd),
      .commit_old_prd(commit_old_prd), .commit_pc(commit_pc), .commit_instr(commit_instr),
      .redirect_valid(redirect_valid), .redirect_robflag(redirect_robflag),
      .redirect_robidx(redirect_robidx),
      .empty(empty), .full(full), .count(count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int nvec = 0;
   int nfail = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_idle();
      enq_valid = '0; enq_need_wb = '0; enq_lrd = '0; enq_prd = '0; enq_old_prd = '0;
      enq_pc = '0; enq_instr = '0;
      wb_valid = '0; wb_robflag = '0; wb_robidx = '0;
      redirect_valid = 1'b0; redirect_robflag = 1'b0; redirect_robidx = '0;
   endtask

   task automatic next();
      @(posedge clock); #1;
      set_idle();
   endtask

   // Reference model: live entries oldest-first plus the enqueue pointer.
   typedef struct {
      logic flag; int idx; logic done;
      logic [LREG_W-1:0] lrd; logic [PREG_W-1:0] prd, oprd;
      logic [47:0] pc; logic [31:0] ins;
   } ment_t;
   ment_t mq[$];
   int menq;

   task automatic do_reset();
      reset_n = 1'b0;
      set_idle();
      @(posedge clock); #1;
      chk("reset_state", {commit_valid, empty, full, count, enq_ready, enq_robflag, enq_robidx},
          {2'b00, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 6'd0});
      reset_n = 1'b1;
      mq.delete();
      menq = 0;
   endtask

   typedef struct {
      logic [1:0] ev, nwb; logic [2:0] wv, wf;
      logic [5:0] w0, w1, w2;
      logic [1:0] ecv; int ecnt; int eidx; logic erdy;
   } vec_t;
   vec_t tbl [17];

   task automatic model_cycle(input int cyc);
      int sz, j, n, rp;
      ment_t t;
      logic [CMT_W*LREG_W-1:0] el, al;
      logic [CMT_W*PREG_W-1:0] ep, ap, eo, ao;
      logic [CMT_W*48-1:0] epc, apc;
      logic [CMT_W*32-1:0] ein, ain;
      logic [CMT_W-1:0] ecv;
      logic erdy;
      sz = mq.size();
      j = -1;
      if (redirect_valid)
         for (int i = 0; i < sz; i++)
            if (mq[i].idx == int'(redirect_robidx) && mq[i].flag == redirect_robflag) j = i;
      n = 0;
      while (n < CMT_W && n < sz && mq[n].done && (j < 0 || n <= j)) n++;
      ecv = '0; el = '0; al = '0; ep = '0; ap = '0; eo = '0; ao = '0;
      epc = '0; apc = '0; ein = '0; ain = '0;
      for (int k = 0; k < n; k++) begin
         ecv[k] = 1'b1;
         el[k*LREG_W +: LREG_W] = mq[k].lrd;  al[k*LREG_W +: LREG_W] = commit_lrd[k*LREG_W +: LREG_W];
         ep[k*PREG_W +: PREG_W] = mq[k].prd;  ap[k*PREG_W +: PREG_W] = commit_prd[k*PREG_W +: PREG_W];
         eo[k*PREG_W +: PREG_W] = mq[k].oprd; ao[k*PREG_W +: PREG_W] = commit_old_prd[k*PREG_W +: PREG_W];
         epc[k*48 +: 48] = mq[k].pc;  apc[k*48 +: 48] = commit_pc[k*48 +: 48];
         ein[k*32 +: 32] = mq[k].ins; ain[k*32 +: 32] = commit_instr[k*32 +: 32];
      end
      erdy = ((DEPTH - sz) >= ENQ_W) && !redirect_valid;
      chk($sformatf("rnd%0d_cv", cyc), commit_valid, ecv);
      chk($sformatf("rnd%0d_occ", cyc), {empty, full, count}, {sz == 0, sz == DEPTH, 7'(sz)});
      chk($sformatf("rnd%0d_enq", cyc), {enq_ready, enq_robflag, enq_robidx},
          {erdy, 1'((menq / DEPTH) % 2), 6'(menq % DEPTH)});
      chk($sformatf("rnd%0d_fields", cyc), {al, ap, ao}, {el, ep, eo});
`ifdef ROB_DEBUG_INFO_EN
      chk($sformatf("rnd%0d_pc", cyc), apc, epc);
      chk($sformatf("rnd%0d_instr", cyc), ain, ein);
`else
      chk($sformatf("rnd%0d_dbg", cyc), {|commit_pc, |commit_instr}, 2'b00);
`endif
      for (int p = 0; p < WB_PORTS; p++)
         if (wb_valid[p])
            for (int i = 0; i < mq.size(); i++)
               if (mq[i].idx == int'(wb_robidx[p*IDX_W +: IDX_W]) && mq[i].flag == wb_robflag[p]) begin
                  t = mq[i]; t.done = 1'b1; mq[i] = t;
               end
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      if (j >= 0) begin
         while (mq.size() > j - n + 1) void'(mq.pop_back());
         rp = int'(redirect_robflag) * DEPTH + int'(redirect_robidx);
         menq = (rp + 1) % (2 * DEPTH);
      end else if (erdy) begin
         for (int k = 0; k < ENQ_W; k++) begin
            if (!enq_valid[k]) break;
            t.flag = 1'((menq / DEPTH) % 2); t.idx = menq % DEPTH; t.done = !enq_need_wb[k];
            t.lrd = enq_lrd[k*LREG_W +: LREG_W]; t.prd = enq_prd[k*PREG_W +: PREG_W];
            t.oprd = enq_old_prd[k*PREG_W +: PREG_W];
            t.pc = enq_pc[k*48 +: 48]; t.ins = enq_instr[k*32 +: 32];
            mq.push_back(t);
            menq = (menq + 1) % (2 * DEPTH);
         end
      end
   endtask

   initial begin
      int pick, prob;
      reset_n = 1'b0;
      set_idle();
      //            ev     nwb    wv      wf      w0    w1    w2    ecv   cnt idx rdy
      tbl[0]  = '{2'b11, 2'b00, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b00, 0, 0, 1'b1};
      tbl[1]  = '{2'b00, 2'b00, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b11, 2, 2, 1'b1};
      tbl[2]  = '{2'b00, 2'b00, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b00, 0, 2, 1'b1};
      tbl[3]  = '{2'b11, 2'b11, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b00, 0, 2, 1'b1};
      tbl[4]  = '{2'b00, 2'b00, 3'b001, 3'b000, 6'd3, 6'd0, 6'd0, 2'b00, 2, 4, 1'b1};
      tbl[5]  = '{2'b00, 2'b00, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b00, 2, 4, 1'b1};
      tbl[6]  = '{2'b00, 2'b00, 3'b110, 3'b000, 6'd0, 6'd2, 6'd2, 2'b00, 2, 4, 1'b1};
      tbl[7]  = '{2'b00, 2'b00, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b11, 2, 4, 1'b1};
      tbl[8]  = '{2'b01, 2'b01, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b00, 0, 4, 1'b1};
      tbl[9]  = '{2'b10, 2'b00, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b00, 1, 5, 1'b1};
      tbl[10] = '{2'b00, 2'b00, 3'b001, 3'b001, 6'd4, 6'd0, 6'd0, 2'b00, 1, 5, 1'b1};
      tbl[11] = '{2'b00, 2'b00, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b00, 1, 5, 1'b1};
      tbl[12] = '{2'b00, 2'b00, 3'b001, 3'b000, 6'd4, 6'd0, 6'd0, 2'b00, 1, 5, 1'b1};
      tbl[13] = '{2'b00, 2'b00, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b01, 1, 5, 1'b1};
      tbl[14] = '{2'b01, 2'b00, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b00, 0, 5, 1'b1};
      tbl[15] = '{2'b11, 2'b11, 3'b001, 3'b001, 6'd6, 6'd0, 6'd0, 2'b01, 1, 6, 1'b1};
      tbl[16] = '{2'b00, 2'b00, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 2'b00, 2, 8, 1'b1};

      // Two done-at-enqueue entries retire together with their fields in lane order.
      do_reset();
      enq_valid = 2'b11; enq_need_wb = 2'b00;
      enq_lrd = {5'd9, 5'd3}; enq_prd = {6'd20, 6'd10}; enq_old_prd = {6'd21, 6'd11};
      next(); #1;
      chk("basic_cv", commit_valid, 2'b11);
      chk("basic_fields", {commit_lrd, commit_prd, commit_old_prd},
          {5'd9, 5'd3, 6'd20, 6'd10, 6'd21, 6'd11});
      next(); #1;
      chk("basic_drain", {empty, count}, {1'b1, 7'd0});

      do_reset();
      for (int r = 0; r < 17; r++) begin
         enq_valid = tbl[r].ev; enq_need_wb = tbl[r].nwb;
         wb_valid = tbl[r].wv; wb_robflag = tbl[r].wf;
         wb_robidx = {tbl[r].w2, tbl[r].w1, tbl[r].w0};
         #1;
         chk($sformatf("tbl%0d_cv", r), commit_valid, tbl[r].ecv);
         chk($sformatf("tbl%0d_cnt", r), count, 7'(tbl[r].ecnt));
         chk($sformatf("tbl%0d_enq", r), {enq_ready, enq_robidx}, {tbl[r].erdy, 6'(tbl[r].eidx)});
         next();
      end

      // Fill to capacity, retire two, then enqueue into the wrapped slots.
      do_reset();
      for (int c = 0; c < DEPTH / 2; c++) begin
         enq_valid = 2'b11; enq_need_wb = 2'b11;
         next();
      end
      #1;
      chk("full_state", {full, count, enq_ready, enq_robflag, enq_robidx}, {1'b1, 7'd64, 1'b0, 1'b1, 6'd0});
      wb_valid = 3'b011; wb_robidx = {6'd0, 6'd1, 6'd0};
      next(); #1;
      chk("full_commit", {commit_valid, enq_ready}, {2'b11, 1'b0});
      next();
      enq_valid = 2'b11; enq_need_wb = 2'b00;
      #1;
      chk("wrap_enq", {enq_ready, enq_robflag, enq_robidx, count}, {1'b1, 1'b1, 6'd0, 7'd62});
      next(); #1;
      chk("wrap_full", {full, count}, {1'b1, 7'd64});
      for (int b = 2; b < DEPTH; b += 3) begin
         for (int p = 0; p < WB_PORTS; p++)
            if (b + p < DEPTH) begin
               wb_valid[p] = 1'b1;
               wb_robidx[p*IDX_W +: IDX_W] = 6'(b + p);
            end
         next();
      end
      for (int c = 0; c < 200 && !empty; c++) next();
      #1;
      chk("wrap_drain", {empty, count, enq_robflag, enq_robidx}, {1'b1, 7'd0, 1'b1, 6'd2});

      // Redirect at idx 4 drops 5..9 and rewinds the enqueue pointer.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         enq_valid = 2'b11; enq_need_wb = 2'b11;
         next();
      end
      redirect_valid = 1'b1; redirect_robflag = 1'b0; redirect_robidx = 6'd4;
      enq_valid = 2'b11;
      #1;
      chk("redir_block", {enq_ready, count}, {1'b0, 7'd10});
      next(); #1;
      chk("redir_after", {enq_robidx, count}, {6'd5, 7'd5});
      wb_valid = 3'b011; wb_robidx = {6'd0, 6'd0, 6'd7};
      next(); #1;
      chk("redir_wb7", {commit_valid, count}, {2'b01, 7'd5});
      wb_valid = 3'b111; wb_robidx = {6'd3, 6'd2, 6'd1};
      next();
      wb_valid = 3'b001; wb_robidx = {6'd0, 6'd0, 6'd4};
      next();
      for (int c = 0; c < 20 && !empty; c++) next();
      #1;
      chk("redir_drain", {empty, enq_robidx}, {1'b1, 6'd5});

      // Asynchronous reset with committable entries present.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         enq_valid = 2'b11; enq_need_wb = 2'b11;
         next();
      end
      wb_valid = 3'b011; wb_robidx = {6'd0, 6'd1, 6'd0};
      next(); #1;
      chk("mid_pre", {commit_valid, count}, {2'b11, 7'd20});
      reset_n = 1'b0;
      #1;
      chk("mid_reset", {commit_valid, empty, full, count, enq_ready, enq_robflag, enq_robidx},
          {2'b00, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 6'd0});
      @(posedge clock); #1;
      chk("mid_hold", {commit_valid, count}, {2'b00, 7'd0});
      reset_n = 1'b1;
      next(); #1;
      chk("mid_release", {commit_valid, empty}, {2'b00, 1'b1});

      // Randomized traffic against the queue model.
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         enq_valid = ENQ_W'($urandom_range(0, (1 << ENQ_W) - 1));
         for (int k = 0; k < ENQ_W; k++) begin
            enq_need_wb[k] = ($urandom_range(0, 9) < 7);
            enq_lrd[k*LREG_W +: LREG_W] = LREG_W'($urandom);
            enq_prd[k*PREG_W +: PREG_W] = PREG_W'($urandom);
            enq_old_prd[k*PREG_W +: PREG_W] = PREG_W'($urandom);
            enq_pc[k*48 +: 48] = {16'($urandom), 32'($urandom)};
            enq_instr[k*32 +: 32] = $urandom;
         end
         prob = ((cyc / 400) % 2 == 1) ? 70 : 20;
         for (int p = 0; p < WB_PORTS; p++)
            if (mq.size() > 0 && $urandom_range(0, 99) < prob) begin
               pick = $urandom_range(0, mq.size() - 1);
               wb_valid[p] = 1'b1;
               wb_robidx[p*IDX_W +: IDX_W] = IDX_W'(mq[pick].idx);
               wb_robflag[p] = mq[pick].flag ^ ($urandom_range(0, 9) == 0);
            end
         if ($urandom_range(0, 99) < 3) begin
            redirect_valid = 1'b1;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
               pick = $urandom_range(0, mq.size() - 1);
               redirect_robidx = IDX_W'(mq[pick].idx);
               redirect_robflag = mq[pick].flag;
            end else begin
               redirect_robidx = IDX_W'($urandom);
               redirect_robflag = 1'($urandom);
            end
         end
         #1;
         model_cycle(cyc);
         next();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
